midway_scanout_pipeline: RTL and testbench

- Pipelined successor to the combinational Midway 8080 framebuffer adapter.
- Converts VGA raster coordinates into Midway video-RAM byte addresses and issues a read per pixel.
- Absorbs the RAM's synchronous read latency; selects the pixel bit and emits registered RGB plus delay-matched sync/DE.
- Sits between the VGA timing generator and the dual-port video RAM (read port); source image is 224x256, rotated bottom-up, integer-upscaled and centred.

---
 rtl/midway_scanout_pipeline.sv | 273 +++++++++++++++++++++++++++
 tb/tb_midway_scanout_pipeline.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midway_scanout_pipeline.sv
// ============================================================================
// midway_scanout_pipeline
//
// Purpose:
//   Pipelined scan-out adapter between a VGA timing generator and the read
//   port of a Midway 8080 style video RAM. Each VGA coordinate is mapped into
//   the 224x256 source image. The image is stored rotated, with each RAM
//   column holding one source x and bytes packed bottom-up, and it is
//   integer-upscaled and placed at an offset. One RAM read is issued per
//   pixel. The synchronous read latency of the RAM is absorbed by a delay
//   line, and the addressed bit is turned into a registered RGB value.
//   Sync and display-enable are delayed to stay aligned with the colour.
//
//   Latency from in_* to out_* is 2 + RAM_LATENCY clocks. Throughput is
//   one pixel per clock, with no bubbles.
//
// Optional feature:
//   MIDWAY_COLOR_OVERLAY_EN - when defined, the colour of a set pixel comes
//   from the source-row band, emulating the cabinet gel overlay. When it is
//   undefined, every set pixel uses FG_RGB and no band logic is built.
//
// Ports:
//   clk        in   pixel clock
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   in_x/in_y/syncs valid this cycle
//   in_x       in   [9:0] VGA column
//   in_y       in   [8:0] VGA row
//   in_de      in   VGA display enable
//   in_hsync   in   VGA hsync
//   in_vsync   in   VGA vsync
//   mem_x      out  [7:0] RAM column address (source x)
//   mem_y      out  [4:0] RAM byte-row address
//   mem_rd     out  read strobe
//   mem_data   in   [7:0] byte returned RAM_LATENCY clocks after mem_rd
//   out_valid  out  output pixel valid
//   out_rgb    out  [23:0] pixel colour
//   out_de     out  delayed in_de
//   out_hsync  out  delayed in_hsync
//   out_vsync  out  delayed in_vsync
// ============================================================================
module midway_scanout_pipeline #(
    parameter int          SRC_W       = 224,
    parameter int          SRC_H       = 256,
    parameter int          SCALE       = 1,
    parameter int          X_OFFSET    = 0,
    parameter int          Y_OFFSET    = 0,
    parameter int          RAM_LATENCY = 1,
    parameter logic [23:0] FG_RGB      = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB      = 24'h000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [9:0]  in_x,
    input  logic [8:0]  in_y,
    input  logic        in_de,
    input  logic        in_hsync,
    input  logic        in_vsync,
    output logic [7:0]  mem_x,
    output logic [4:0]  mem_y,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    output logic        out_valid,
    output logic [23:0] out_rgb,
    output logic        out_de,
    output logic        out_hsync,
    output logic        out_vsync
);

    // Per-pixel attributes that travel alongside the RAM read.
    typedef struct packed {
        logic       valid;
        logic       de;
        logic       hsync;
        logic       vsync;
        logic       win;
        logic [2:0] bit_idx;
`ifdef MIDWAY_COLOR_OVERLAY_EN
        logic [1:0] band;     // 0: FG_RGB, 1: red gel, 2: green gel
`endif
    } pipe_t;

    // ------------------------------------------------------------------
    // Stage A: coordinate mapping (combinational part)
    // ------------------------------------------------------------------
    // The 11-bit differences make the left and top borders negative, so
    // they can never wrap around into valid RAM addresses.
    logic [10:0] dx;
    logic [10:0] dy;
    logic        in_win;
    logic [7:0]  sx;
    logic [7:0]  sy;
    logic [4:0]  row_byte;

    assign dx = 11'({1'b0, in_x}) - 11'(X_OFFSET);
    assign dy = 11'({2'b0, in_y}) - 11'(Y_OFFSET);

    // The comparisons use 12 bits, because SRC_H*SCALE can reach 1024.
    assign in_win = !dx[10] && ({1'b0, dx} < 12'(SRC_W * SCALE)) &&
                    !dy[10] && ({1'b0, dy} < 12'(SRC_H * SCALE));

    // The divide is by a constant. Power-of-two scales reduce to shifts.
    assign sx = 8'(dx[9:0] / 10'(SCALE));
    assign sy = 8'(dy[9:0] / 10'(SCALE));

    // The image is stored bottom-up: source row 0 is the MSB of the last byte.
    assign row_byte = 5'((8'(SRC_H - 1) - sy) >> 3);

`ifdef MIDWAY_COLOR_OVERLAY_EN
    logic [1:0] band;

    always_comb begin
        band = 2'd0;
        if (sy >= 8'd32 && sy <= 8'd63) begin
            band = 2'd1;
        end else if (sy >= 8'd184 && sy <= 8'd239) begin
            band = 2'd2;
        end else if (sy >= 8'd240 && sx >= 8'd16 && sx <= 8'd133) begin
            band = 2'd2;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Stage A: registers
    // ------------------------------------------------------------------
    pipe_t      a_q;
    pipe_t      a_d;
    logic [7:0] mem_x_q;
    logic [7:0] mem_x_d;
    logic [4:0] mem_y_q;
    logic [4:0] mem_y_d;
    logic       mem_rd_q;
    logic       mem_rd_d;

    always_comb begin
        a_d       = a_q;
        a_d.valid = in_valid;
        mem_x_d   = mem_x_q;
        mem_y_d   = mem_y_q;
        mem_rd_d  = in_valid && in_win && in_de;
        // The sideband is captured only on valid samples. Idle cycles
        // keep the previous value, so the syncs do not advance on them.
        if (in_valid) begin
            a_d.de      = in_de;
            a_d.hsync   = in_hsync;
            a_d.vsync   = in_vsync;
            a_d.win     = in_win;
            a_d.bit_idx = 3'd7 - sy[2:0];
`ifdef MIDWAY_COLOR_OVERLAY_EN
            a_d.band    = band;
`endif
            // The address is held outside the window, so border pixels do
            // not cause address activity on the RAM port.
            if (in_win) begin
                mem_x_d = sx;
                mem_y_d = row_byte;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q      <= '0;
            mem_x_q  <= '0;
            mem_y_q  <= '0;
            mem_rd_q <= 1'b0;
        end else begin
            a_q      <= a_d;
            mem_x_q  <= mem_x_d;
            mem_y_q  <= mem_y_d;
            mem_rd_q <= mem_rd_d;
        end
    end

    assign mem_x  = mem_x_q;
    assign mem_y  = mem_y_q;
    assign mem_rd = mem_rd_q;

    // ------------------------------------------------------------------
    // Delay line: RAM_LATENCY stages, so that the attributes arrive at
    // stage C in the same cycle as the matching mem_data byte.
    // ------------------------------------------------------------------
    pipe_t dly_chain [RAM_LATENCY + 1];

    assign dly_chain[0] = a_q;

    for (genvar gi = 0; gi < RAM_LATENCY; gi++) begin : g_dly
        pipe_t stage_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                stage_q <= '0;
            end else begin
                stage_q <= dly_chain[gi];
            end
        end

        assign dly_chain[gi + 1] = stage_q;
    end

    pipe_t aligned;
    assign aligned = dly_chain[RAM_LATENCY];

    // ------------------------------------------------------------------
    // Stage C: pixel selection and output registers
    // ------------------------------------------------------------------
    logic [23:0] fg_rgb;
    logic        pix_set;

    always_comb begin
        fg_rgb = FG_RGB;
`ifdef MIDWAY_COLOR_OVERLAY_EN
        if (aligned.band == 2'd1) begin
            fg_rgb = 24'hFF0000;
        end else if (aligned.band == 2'd2) begin
            fg_rgb = 24'h00FF00;
        end
`endif
    end

    // mem_data only counts for in-window displayed pixels. On a border
    // pixel the RAM was not read, so its output is stale.
    assign pix_set = aligned.win && aligned.de && mem_data[aligned.bit_idx];

    logic        out_valid_q;
    logic        out_valid_d;
    logic [23:0] out_rgb_q;
    logic [23:0] out_rgb_d;
    logic        out_de_q;
    logic        out_de_d;
    logic        out_hsync_q;
    logic        out_hsync_d;
    logic        out_vsync_q;
    logic        out_vsync_d;

    always_comb begin
        out_valid_d = aligned.valid;
        out_rgb_d   = out_rgb_q;
        out_de_d    = out_de_q;
        out_hsync_d = out_hsync_q;
        out_vsync_d = out_vsync_q;
        if (aligned.valid) begin
            out_rgb_d   = pix_set ? fg_rgb : BG_RGB;
            out_de_d    = aligned.de;
            out_hsync_d = aligned.hsync;
            out_vsync_d = aligned.vsync;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_rgb_q   <= '0;
            out_de_q    <= 1'b0;
            out_hsync_q <= 1'b0;
            out_vsync_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_rgb_q   <= out_rgb_d;
            out_de_q    <= out_de_d;
            out_hsync_q <= out_hsync_d;
            out_vsync_q <= out_vsync_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_rgb   = out_rgb_q;
    assign out_de    = out_de_q;
    assign out_hsync = out_hsync_q;
    assign out_vsync = out_vsync_q;

endmodule

// File: tb/tb_midway_scanout_pipeline.sv
// ============================================================================
// tb_midway_scanout_pipeline
//
// Purpose:
//   Four instances of midway_scanout_pipeline share one stimulus stream:
//     - RAM latencies 1, 2 and 3 at scale 1 (one of them with offsets)
//     - scale 2 with a horizontal offset of 96
//   A reference model computes the expected RAM address and pixel colour for
//   each instance from the image geometry. The model works in plain
//   integers: it flips the source row, takes the byte as row/8 and the bit
//   as row%8. Expected values go into per-instance queues. A monitor on the
//   falling edge compares every presented output against the queue, and
//   checks that each output appears in exactly the expected cycle.
// ============================================================================
module tb_midway_scanout_pipeline;

    localparam int NI = 4;

    function automatic int lat_of(input int i);
        case (i)
            1:       return 2;
            2:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int scale_of(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    function automatic int xoff_of(input int i);
        case (i)
            2:       return 48;
            3:       return 96;
            default: return 0;
        endcase
    endfunction

    function automatic int yoff_of(input int i);
        return (i == 2) ? 8 : 0;
    endfunction

    typedef struct packed {
        logic [31:0] due;
        logic [23:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
    } exp_t;

    typedef struct packed {
        logic [31:0] due;
        logic        rd;
        logic [7:0]  x;
        logic [4:0]  y;
    } mem_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [9:0]  in_x = '0;
    logic [8:0]  in_y = '0;
    logic        in_de = 1'b0;
    logic        in_hsync = 1'b0;
    logic        in_vsync = 1'b0;
    logic        done = 1'b0;
    logic [31:0] cyc = '0;

    logic [NI-1:0][7:0]  mem_x_w;
    logic [NI-1:0][4:0]  mem_y_w;
    logic [NI-1:0]       mem_rd_w;
    logic [NI-1:0][7:0]  mem_data_w;
    logic [NI-1:0]       ov_w;
    logic [NI-1:0][23:0] rgb_w;
    logic [NI-1:0]       ode_w;
    logic [NI-1:0]       ohs_w;
    logic [NI-1:0]       ovs_w;

    logic [7:0] ram [256][32];

    exp_t pix_q [NI][$];
    mem_t memq  [NI][$];
    int   last_x [NI];
    int   last_y [NI];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
        logic [7:0] rd_pipe [3];

        // Synchronous-read RAM with a selectable latency.
        always @(posedge clk) begin
            rd_pipe[0] <= ram[mem_x_w[gi]][mem_y_w[gi]];
            rd_pipe[1] <= rd_pipe[0];
            rd_pipe[2] <= rd_pipe[1];
        end

        assign mem_data_w[gi] = rd_pipe[lat_of(gi) - 1];

        midway_scanout_pipeline #(
            .SRC_W       (224),
            .SRC_H       (256),
            .SCALE       (scale_of(gi)),
            .X_OFFSET    (xoff_of(gi)),
            .Y_OFFSET    (yoff_of(gi)),
            .RAM_LATENCY (lat_of(gi)),
            .FG_RGB      (24'hFFFFFF),
            .BG_RGB      (24'h000000)
        ) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .in_valid  (in_valid),
            .in_x      (in_x),
            .in_y      (in_y),
            .in_de     (in_de),
            .in_hsync  (in_hsync),
            .in_vsync  (in_vsync),
            .mem_x     (mem_x_w[gi]),
            .mem_y     (mem_y_w[gi]),
            .mem_rd    (mem_rd_w[gi]),
            .mem_data  (mem_data_w[gi]),
            .out_valid (ov_w[gi]),
            .out_rgb   (rgb_w[gi]),
            .out_de    (ode_w[gi]),
            .out_hsync (ohs_w[gi]),
            .out_vsync (ovs_w[gi])
        );
    end

    // Drive one cycle of input and queue the expected responses.
    task automatic apply(input logic v, input logic [9:0] x, input logic [8:0] y,
                         input logic de, input logic hs, input logic vs);
        @(negedge clk);
        in_valid = v;
        in_x     = x;
        in_y     = y;
        in_de    = de;
        in_hsync = hs;
        in_vsync = vs;
        for (int i = 0; i < NI; i++) begin
            int          s, dx, dy, sx, sy, r;
            logic        win, setb;
            logic [7:0]  b;
            logic [23:0] fg;
            exp_t        e;
            mem_t        m;
            s   = scale_of(i);
            dx  = int'(x) - xoff_of(i);
            dy  = int'(y) - yoff_of(i);
            win = (dx >= 0) && (dx < 224 * s) && (dy >= 0) && (dy < 256 * s);
            sx  = win ? dx / s : 0;
            sy  = win ? dy / s : 0;
            r   = 255 - sy;
            b   = ram[8'(sx)][5'(r / 8)];
            setb = win && de && b[3'(r % 8)];
            fg  = 24'hFFFFFF;
`ifdef MIDWAY_COLOR_OVERLAY_EN
            if (sy >= 32 && sy <= 63) fg = 24'hFF0000;
            else if (sy >= 184 && sy <= 239) fg = 24'h00FF00;
            else if (sy >= 240 && sx >= 16 && sx <= 133) fg = 24'h00FF00;
`endif
            if (v && win) begin
                last_x[i] = sx;
                last_y[i] = r / 8;
            end
            m.due = cyc + 32'd1;
            m.rd  = v && win && de;
            m.x   = 8'(last_x[i]);
            m.y   = 5'(last_y[i]);
            memq[i].push_back(m);
            if (v) begin
                e.due = cyc + 32'(2 + lat_of(i));
                e.rgb = setb ? fg : 24'h000000;
                e.de  = de;
                e.hs  = hs;
                e.vs  = vs;
                pix_q[i].push_back(e);
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            last_x[i] = 0;
            last_y[i] = 0;
        end
    endtask

    // Monitor: all comparisons happen here.
    always @(negedge clk) begin
        mem_t m;
        exp_t e;
        if (!reset_n) begin
            for (int i = 0; i < NI; i++) begin
                checks++;
                if ({mem_x_w[i], mem_y_w[i], mem_rd_w[i], ov_w[i], rgb_w[i],
                     ode_w[i], ohs_w[i], ovs_w[i]} !== '0) begin
                    failures++;
                    $display("FAIL reset_state inst=%0d got x=%0d y=%0d rd=%b ov=%b rgb=%06h de=%b hs=%b vs=%b want all zero",
                             i, mem_x_w[i], mem_y_w[i], mem_rd_w[i], ov_w[i], rgb_w[i],
                             ode_w[i], ohs_w[i], ovs_w[i]);
                end
                pix_q[i].delete();
                memq[i].delete();
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (memq[i].size() > 0 && memq[i][0].due == cyc) begin
                    m = memq[i].pop_front();
                    checks++;
                    if (mem_rd_w[i] !== m.rd || mem_x_w[i] !== m.x || mem_y_w[i] !== m.y) begin
                        failures++;
                        $display("FAIL mem_addr inst=%0d cyc=%0d got rd=%b x=%0d y=%0d want rd=%b x=%0d y=%0d",
                                 i, cyc, mem_rd_w[i], mem_x_w[i], mem_y_w[i], m.rd, m.x, m.y);
                    end
                end
                if (ov_w[i] === 1'b1) begin
                    checks++;
                    if (pix_q[i].size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_pixel inst=%0d cyc=%0d got rgb=%06h want no output",
                                 i, cyc, rgb_w[i]);
                    end else begin
                        e = pix_q[i].pop_front();
                        if (e.due != cyc || rgb_w[i] !== e.rgb || ode_w[i] !== e.de ||
                            ohs_w[i] !== e.hs || ovs_w[i] !== e.vs) begin
                            failures++;
                            $display("FAIL pixel inst=%0d got cyc=%0d rgb=%06h de=%b hs=%b vs=%b want cyc=%0d rgb=%06h de=%b hs=%b vs=%b",
                                     i, cyc, rgb_w[i], ode_w[i], ohs_w[i], ovs_w[i],
                                     e.due, e.rgb, e.de, e.hs, e.vs);
                        end else begin
                            $display("pix inst=%0d cyc=%0d rgb=%06h de=%b hs=%b vs=%b",
                                     i, cyc, rgb_w[i], ode_w[i], ohs_w[i], ovs_w[i]);
                        end
                    end
                end else if (pix_q[i].size() > 0 && pix_q[i][0].due <= cyc) begin
                    e = pix_q[i].pop_front();
                    checks++;
                    failures++;
                    $display("FAIL missing_pixel inst=%0d cyc=%0d got out_valid=%b want valid rgb=%06h due=%0d",
                             i, cyc, ov_w[i], e.rgb, e.due);
                end
            end
            if (done) begin
                for (int i = 0; i < NI; i++) begin
                    checks++;
                    if (pix_q[i].size() != 0 || memq[i].size() != 0) begin
                        failures++;
                        $display("FAIL drain inst=%0d got pending pix=%0d mem=%0d want 0",
                                 i, pix_q[i].size(), memq[i].size());
                    end
                end
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int x = 0; x < 256; x++)
            for (int b = 0; b < 32; b++)
                ram[x][b] = 8'($urandom);
        ram[5][31] = 8'h80;     // sy=0   -> set, sy=1   -> clear
        ram[5][0]  = 8'h01;     // sy=255 -> set, sy=254 -> clear
        ram[5][26] = ram[5][26] | 8'h80;   // sy=40 set
        ram[5][6]  = ram[5][6]  | 8'h80;   // sy=200 set
        model_reset();

        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;

        // Directed cases
        apply(1'b1, 10'd0,   9'd0,   1'b1, 1'b0, 1'b0);
        apply(1'b1, 10'd5,   9'd0,   1'b1, 1'b0, 1'b0);
        apply(1'b1, 10'd5,   9'd1,   1'b1, 1'b0, 1'b0);
        apply(1'b1, 10'd5,   9'd254, 1'b1, 1'b0, 1'b0);
        apply(1'b1, 10'd5,   9'd255, 1'b1, 1'b0, 1'b0);
        apply(1'b1, 10'd224, 9'd10,  1'b1, 1'b0, 1'b0);
        apply(1'b1, 10'd223, 9'd10,  1'b1, 1'b0, 1'b0);
        apply(1'b0, 10'd300, 9'd10,  1'b1, 1'b1, 1'b1);
        apply(1'b1, 10'd95,  9'd0,   1'b1, 1'b0, 1'b0);
        apply(1'b1, 10'd96,  9'd0,   1'b1, 1'b0, 1'b0);
        apply(1'b1, 10'd97,  9'd0,   1'b1, 1'b0, 1'b0);
        apply(1'b1, 10'd98,  9'd0,   1'b1, 1'b0, 1'b0);
        apply(1'b1, 10'd100, 9'd511, 1'b1, 1'b0, 1'b0);
        apply(1'b1, 10'd5,   9'd40,  1'b1, 1'b0, 1'b0);
        apply(1'b1, 10'd5,   9'd200, 1'b1, 1'b0, 1'b0);
        apply(1'b1, 10'd5,   9'd40,  1'b0, 1'b0, 1'b0);

        // Sync/DE pulse train with occasional gaps
        for (int k = 0; k < 80; k++) begin
            apply((k % 11) != 10, 10'(k * 3), 9'(100 + k / 20),
                  (k % 20) >= 5, (k % 20) < 3, k < 4);
        end

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            apply($urandom_range(0, 7) != 0, 10'($urandom_range(0, 1023)),
                  9'($urandom_range(0, 511)), $urandom_range(0, 3) != 0,
                  1'($urandom), 1'($urandom));
        end

        // Reset mid-line with pixels in flight
        apply(1'b1, 10'd10, 9'd20, 1'b1, 1'b1, 1'b0);
        apply(1'b1, 10'd11, 9'd20, 1'b1, 1'b1, 1'b0);
        apply(1'b1, 10'd12, 9'd20, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        in_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;

        for (int k = 0; k < 150; k++) begin
            apply($urandom_range(0, 5) != 0, 10'($urandom_range(0, 1023)),
                  9'($urandom_range(0, 511)), $urandom_range(0, 3) != 0,
                  1'($urandom), 1'($urandom));
        end

        for (int k = 0; k < 8; k++) begin
            apply(1'b0, 10'd0, 9'd0, 1'b0, 1'b0, 1'b0);
        end
        @(posedge clk);
        done = 1'b1;
    end

endmodule
